// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: four-requester round-robin arbiter in front of a 4:1 word
// mux, feeding a single registered output stage with a valid/ready handshake.
//
// The round-robin pointer marks the highest-priority requester. After a grant
// it moves to the slot after the winner, so every active requester is served
// in turn. The output register is reloaded whenever it is empty or is being
// drained in the same cycle. This allows one word per cycle with no bubbles.
//
// Optional feature: define ARB_STATS_EN to add the grant_cnt port. It carries
// four 8-bit saturating grant counters, one byte per requester.

module rr_mux_arbiter #(
  parameter int w = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [w-1:0] d0,
  input  logic [w-1:0] d1,
  input  logic [w-1:0] d2,
  input  logic [w-1:0] d3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [w-1:0] out_data,
  output logic [1:0]   out_src
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]  grant_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state_q;
  logic [1:0]     ptr_q;
  logic [w-1:0]   data_q;
  logic [1:0]     src_q;

  logic           load;
  logic           any_req;
  logic [1:0]     winner;
  logic           grant;
  logic [w-1:0]   mux_data;

  // The output register can take a new word when it is empty or is being drained.
  assign load = (state_q == EMPTY) || out_ready;

  // Rotating priority search: the first requester at or after ptr wins.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    any_req = 1'b0;
    winner  = ptr_q;
    // The loop scans from the farthest offset down to 0. Each hit overwrites
    // the previous one, so the closest requester to ptr is the one that stays.
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[ptr_q + 2'(k)]) begin
        winner  = ptr_q + 2'(k);
        any_req = 1'b1;
      end
    end
  end

  // No handshake completes while reset is held, even if requests are pending.
  assign grant = load && any_req && rst_n;

  // Word mux steered by the winning index.
  always_comb begin
    mux_data = d0;
    case (winner)
      2'd0: mux_data = d0;
      2'd1: mux_data = d1;
      2'd2: mux_data = d2;
      2'd3: mux_data = d3;
      default: mux_data = d0;
    endcase
  end

  // One-hot ready to the winner, only when the grant really completes.
  assign req_ready = grant ? (4'b0001 << winner) : 4'b0000;

  // Output FSM together with its payload registers and the round-robin pointer.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= 2'd0;
      data_q  <= '0;
      src_q   <= 2'd0;
    end else if (load) begin
      if (grant) begin
        data_q  <= mux_data;
        src_q   <= winner;
        ptr_q   <= winner + 2'd1;
        state_q <= FULL;
      end else begin
        state_q <= EMPTY;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

`ifdef ARB_STATS_EN
  logic [7:0] cnt_q [4];

  // Per-requester grant counters that stop at 255 instead of wrapping.
  // NOTE: the counters are reset because the count must start from a known value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i] && (cnt_q[i] != 8'hFF)) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  assign grant_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule
